uram_port_arbiter: RTL and testbench

//  Shares one 1R1W UltraRAM macro (512b x 512, registered output + 2-stage pipe, read latency 3) among
//  NUM_RD read and NUM_WR write requesters. Round-robin arbitration per port; tags every read with its

---
 rtl/uram_arb_pkg.sv | 33 +++
 rtl/uram_arb_rsp_fifo.sv | 70 +++++++
 rtl/uram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_arb_pkg.sv
// rtl/uram_arb_pkg.sv - shared widths and round-robin helper for the UltraRAM port arbiter
package uram_arb_pkg;

    localparam int READ_LAT_DEFAULT = 3;
    localparam int MAX_REQ          = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rsp_entry_w(input int num_rd, input int dw);
        return id_w(num_rd) + dw;
    endfunction

    // One-hot grant of the first requester at or after start, wrapping mod n.
    function automatic logic [MAX_REQ-1:0] rr_grant(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         start,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic [2:0]         idx;
        gnt = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(start) + k) % n);
            if (k < n && gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/uram_arb_rsp_fifo.sv
// rtl/uram_arb_rsp_fifo.sv - registered response FIFO, no bypass, push+pop at full allowed
module uram_arb_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop     = pop_i && (count_q != '0);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_i && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                wr_ptr_q <= wrap_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Credit accounting upstream must make this unreachable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push_i && !do_pop && count_q == CW'(DEPTH)));
        end
    end

endmodule

// File: rtl/uram_port_arbiter.sv
// rtl/uram_port_arbiter.sv - shares one 1R1W UltraRAM among round-robin read/write requesters
// Optional: define URAM_ARB_RAW_STALL_EN to defer a read that hits the same-cycle write address.
module uram_port_arbiter
    import uram_arb_pkg::*;
#(
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int DW        = 512,
    parameter int AW        = 9,
    parameter int READ_LAT  = READ_LAT_DEFAULT,
    parameter int RSP_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_RD-1:0]       rd_req_valid,
    output logic [NUM_RD-1:0]       rd_req_ready,
    input  logic [NUM_RD*AW-1:0]    rd_req_addr,
    input  logic [NUM_WR-1:0]       wr_req_valid,
    output logic [NUM_WR-1:0]       wr_req_ready,
    input  logic [NUM_WR*AW-1:0]    wr_req_addr,
    input  logic [NUM_WR*DW-1:0]    wr_req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [id_w(NUM_RD)-1:0] rsp_id,
    output logic [DW-1:0]           rsp_data,
    output logic                    mem_rd_en,
    output logic [AW-1:0]           mem_rd_addr,
    output logic                    mem_wr_en,
    output logic [AW-1:0]           mem_wr_addr,
    output logic [DW-1:0]           mem_wr_data,
    input  logic [DW-1:0]           mem_rdata
);
    localparam int IDW = id_w(NUM_RD);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int EW  = rsp_entry_w(NUM_RD, DW);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } rsp_entry_t;

    logic [2:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NUM_RD-1:0]   rd_cand;
    logic [NUM_WR-1:0]   wr_cand;
    logic [AW-1:0]       rd_sel_addr, wr_sel_addr;
    logic [DW-1:0]       wr_sel_data;
    logic [IDW-1:0]      rd_sel_id;
    logic [2:0]          rd_sel_idx, wr_sel_idx;
    logic                rd_fire, wr_fire, raw_hit, credit_ok, rsp_pop, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [READ_LAT-1:0] trk_vld_q;
    logic [IDW-1:0]      trk_id_q [READ_LAT];
    rsp_entry_t          push_entry, head_entry;

    assign rd_cand = NUM_RD'(rr_grant(MAX_REQ'(rd_req_valid), rd_ptr_q, NUM_RD));
    assign wr_cand = NUM_WR'(rr_grant(MAX_REQ'(wr_req_valid), wr_ptr_q, NUM_WR));

    always_comb begin
        rd_sel_addr = '0;
        rd_sel_id   = '0;
        rd_sel_idx  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_cand[i]) begin
                rd_sel_addr = rd_req_addr[i*AW +: AW];
                rd_sel_id   = IDW'(i);
                rd_sel_idx  = 3'(i);
            end
        end
    end

    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        wr_sel_idx  = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_cand[i]) begin
                wr_sel_addr = wr_req_addr[i*AW +: AW];
                wr_sel_data = wr_req_data[i*DW +: DW];
                wr_sel_idx  = 3'(i);
            end
        end
    end

    // Occupancy counts the exiting tracker entry and credits back a same-cycle pop,
    // which is what lets a 4-deep FIFO sustain one read per cycle at latency 3.
    always_comb begin
        int occ;
        occ = int'(fifo_count) - int'(rsp_pop);
        for (int i = 0; i < READ_LAT; i++) begin
            occ = occ + int'(trk_vld_q[i]);
        end
        credit_ok = (occ < RSP_DEPTH);
    end

`ifdef URAM_ARB_RAW_STALL_EN
    assign raw_hit = wr_fire && (|rd_cand) && (rd_sel_addr == wr_sel_addr);
`else
    assign raw_hit = 1'b0;
`endif

    assign rd_req_ready = (credit_ok && !raw_hit && !reset) ? rd_cand : '0;
    assign wr_req_ready = reset ? '0 : wr_cand;
    assign rd_fire      = |rd_req_ready;
    assign wr_fire      = |wr_req_ready;

    assign mem_rd_en   = rd_fire;
    assign mem_rd_addr = rd_sel_addr;
    assign mem_wr_en   = wr_fire;
    assign mem_wr_addr = wr_sel_addr;
    assign mem_wr_data = wr_sel_data;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd_fire) begin
            rd_ptr_d = (rd_sel_idx == 3'(NUM_RD - 1)) ? 3'd0 : rd_sel_idx + 3'd1;
        end
        if (wr_fire) begin
            wr_ptr_d = (wr_sel_idx == 3'(NUM_WR - 1)) ? 3'd0 : wr_sel_idx + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Tracker mirrors the macro pipeline; the macro itself never resets, so stale data is dropped here.
    always_ff @(posedge clock) begin
        if (reset) begin
            trk_vld_q <= '0;
        end else begin
            trk_vld_q[0] <= rd_fire;
            for (int i = 1; i < READ_LAT; i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        trk_id_q[0] <= rd_sel_id;
        for (int i = 1; i < READ_LAT; i++) begin
            trk_id_q[i] <= trk_id_q[i-1];
        end
    end

    assign push_entry = {trk_id_q[READ_LAT-1], mem_rdata};
    assign rsp_valid  = !fifo_empty && !reset;
    assign rsp_pop    = rsp_valid && rsp_ready;
    assign rsp_id     = head_entry.id;
    assign rsp_data   = head_entry.data;

    uram_arb_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (EW)
    ) u_rsp_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (trk_vld_q[READ_LAT-1]),
        .push_data_i (push_entry),
        .pop_i       (rsp_pop),
        .pop_data_o  (head_entry),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_uram_port_arbiter.sv
// tb/tb_uram_port_arbiter.sv - randomized scoreboard bench for uram_port_arbiter
module tb_uram_port_arbiter;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int DW     = 512;
    localparam int AW     = 9;
    localparam int DEPTH  = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_RD-1:0]    rd_req_valid, rd_req_ready;
    logic [NUM_RD*AW-1:0] rd_req_addr;
    logic [NUM_WR-1:0]    wr_req_valid, wr_req_ready;
    logic [NUM_WR*AW-1:0] wr_req_addr;
    logic [NUM_WR*DW-1:0] wr_req_data;
    logic                 rsp_valid, rsp_ready;
    logic [0:0]           rsp_id;
    logic [DW-1:0]        rsp_data;
    logic                 mem_rd_en, mem_wr_en;
    logic [AW-1:0]        mem_rd_addr, mem_wr_addr;
    logic [DW-1:0]        mem_wr_data, mem_rdata;

    always #5 clock = ~clock;

    uram_port_arbiter #(
        .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DW(DW), .AW(AW), .READ_LAT(3), .RSP_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rdata(mem_rdata)
    );

    // UltraRAM stand-in: read sampled at the edge, three register stages, write after read.
    logic [DW-1:0] uram [1<<AW];
    logic [DW-1:0] pipe1, pipe2, pipe3;
    always @(posedge clock) begin
        if (mem_rd_en) pipe1 <= uram[mem_rd_addr];
        pipe2 <= pipe1;
        pipe3 <= pipe2;
        if (mem_wr_en) uram[mem_wr_addr] <= mem_wr_data;
    end
    assign mem_rdata = pipe3;

    typedef struct {
        int            t;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [1<<AW];
    int            m_rd_ptr = 0, m_wr_ptr = 0, outstanding = 0, cyc = 0;
    int            n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] req, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[3'((start + k) % n)]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Model: expected grants from RR + outstanding-read budget; responses appear 4 cycles after accept.
    task automatic step();
        int  rc, wc, ra, wa;
        bit  pop, rd_go, exp_valid;
        #4;
        if (reset) begin
            check("rd_ready_in_reset", DW'(rd_req_ready), '0);
            check("wr_ready_in_reset", DW'(wr_req_ready), '0);
            check("rsp_valid_in_reset", DW'(rsp_valid), '0);
            check("mem_rd_en_in_reset", DW'(mem_rd_en), '0);
            check("mem_wr_en_in_reset", DW'(mem_wr_en), '0);
        end else begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
            check("rsp_valid", DW'(rsp_valid), DW'(exp_valid));
            if (exp_valid && rsp_valid) begin
                check("rsp_id", DW'(rsp_id), DW'(exp_q[0].id));
                check("rsp_data", rsp_data, exp_q[0].data);
            end
            pop   = exp_valid && rsp_ready;
            rc    = rr_pick(8'(rd_req_valid), m_rd_ptr, NUM_RD);
            wc    = rr_pick(8'(wr_req_valid), m_wr_ptr, NUM_WR);
            ra    = (rc >= 0) ? int'(rd_req_addr[rc*AW +: AW]) : 0;
            wa    = (wc >= 0) ? int'(wr_req_addr[wc*AW +: AW]) : 0;
            rd_go = (rc >= 0) && ((outstanding - int'(pop)) < DEPTH);
`ifdef URAM_ARB_RAW_STALL_EN
            if (rd_go && wc >= 0 && ra == wa) rd_go = 1'b0;
`endif
            check("rd_ready", DW'(rd_req_ready), rd_go ? DW'(1 << rc) : '0);
            check("wr_ready", DW'(wr_req_ready), (wc >= 0) ? DW'(1 << wc) : '0);
            check("mem_rd_en", DW'(mem_rd_en), DW'(rd_go));
            if (rd_go) check("mem_rd_addr", DW'(mem_rd_addr), DW'(ra));
            if (pop) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
            if (rd_go) begin
                exp_q.push_back('{cyc + 4, rc, shadow[ra]});
                outstanding++;
                m_rd_ptr = (rc + 1) % NUM_RD;
            end
            if (wc >= 0) begin
                shadow[wa] = wr_req_data[wc*DW +: DW];
                m_wr_ptr   = (wc + 1) % NUM_WR;
            end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            exp_q.delete();
            outstanding = 0;
            m_rd_ptr    = 0;
            m_wr_ptr    = 0;
        end
        cyc++;
    endtask

    task automatic set_idle();
        rd_req_valid = '0;
        wr_req_valid = '0;
    endtask

    task automatic set_rd(input int idx, input int addr);
        rd_req_valid[idx]          = 1'b1;
        rd_req_addr[idx*AW +: AW]  = AW'(addr);
    endtask

    task automatic set_wr(input int idx, input int addr, input logic [DW-1:0] data);
        wr_req_valid[idx]          = 1'b1;
        wr_req_addr[idx*AW +: AW]  = AW'(addr);
        wr_req_data[idx*DW +: DW]  = data;
    endtask

    initial begin
        rd_req_addr = '0;
        wr_req_addr = '0;
        wr_req_data = '0;
        rsp_ready   = 1'b1;
        set_idle();
        set_rd(0, 1);
        set_wr(1, 2, rand_data());
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        set_idle();

        // Preload every address the bench will ever read.
        for (int a = 0; a < 16; a++) begin
            set_idle();
            set_wr(0, a, rand_data());
            step();
        end
        set_idle();

        // Write then read back addr 5, latency 4.
        set_wr(0, 5, {64{8'hA5}});
        step();
        set_idle();
        set_rd(0, 5);
        step();
        set_idle();
        repeat (6) step();

        // Two readers held valid: alternate grants from requester 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_rd(0, 1);
        set_rd(1, 2);
        repeat (8) step();
        set_idle();
        repeat (6) step();

        // Backpressure: only DEPTH reads accepted, then drain and resume.
        rsp_ready = 1'b0;
        set_rd(0, 3);
        repeat (8) step();
        rsp_ready = 1'b1;
        repeat (6) step();
        set_idle();
        repeat (8) step();

        // Same-cycle read/write to addr 7.
        set_wr(0, 7, {64{8'h11}});
        step();
        set_idle();
        step();
        set_rd(0, 7);
        set_wr(0, 7, {64{8'h22}});
        step();
        wr_req_valid = '0;
        step();
        set_idle();
        repeat (8) step();

        // Reset with two reads in flight and one in the FIFO.
        rsp_ready = 1'b0;
        set_rd(1, 4);
        step();
        set_idle();
        step();
        set_rd(1, 6);
        repeat (2) step();
        set_rd(0, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) step();
        set_idle();
        repeat (8) step();

        // Randomized traffic with occasional resets and backpressure.
        repeat (3000) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_req_valid[i]         = ($urandom_range(0, 99) < 60);
                rd_req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            end
            for (int i = 0; i < NUM_WR; i++) begin
                wr_req_valid[i]         = ($urandom_range(0, 99) < 40);
                wr_req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                wr_req_data[i*DW +: DW] = rand_data();
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset     = 1'b0;
        rsp_ready = 1'b1;
        set_idle();
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
